mdu_iterative: RTL and testbench
================================

// Module: mdu_iterative
// PURPOSE
// Parametrised iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
// Executes MULT/MULTU/DIV/DIVU over WIDTH radix-2 iterations plus one sign-fix cycle.
// Sits beside the EX-stage ALU; raises stall so the hazard unit holds the front end on HI/LO conflicts.
// Replaces the single-cycle multordiv path and keeps MTHI/MTLO/MFHI/MFLO semantics.
// PARAMETERS
// WIDTH    32   operand and HI/LO width in bits; legal range 4..64
// PORTS
// clk      in   1      rising-edge clock
// reset    in   1      asynchronous, active-high reset
// start    in   1      launch operation (EX stage, multordivE)
// op       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
// srca     in   WIDTH  multiplicand / dividend
// srcb     in   WIDTH  multiplier / divisor
// hiwe     in   1      MTHI write strobe
// lowe     in   1      MTLO write strobe
// hlwd     in   WIDTH  MTHI/MTLO write data
// rd_hilo  in   1      MFHI/MFLO in EX this cycle
// busy     out  1      operation in flight
// done     out  1      one-cycle pulse: HI/LO just updated by an operation
// stall    out  1      busy & (rd_hilo | start)
// hi       out  WIDTH  HI register
// lo       out  WIDTH  LO register
// div0     out  1      sticky divide-by-zero flag (MDU_DIV0_FLAG_EN only)
// BEHAVIOUR
// - Reset (async, any state, incl. mid-operation): state IDLE, hi=lo=0, busy=0, done=0, div0=0; op aborted.
// - States: IDLE -> RUN (start sampled) -> FIX (after WIDTH iterations) -> IDLE.
// - Edge t samples start=1 in IDLE: operands and op latched, magnitudes taken for signed ops, count=WIDTH-1.
// - Edges t+1..t+WIDTH: one shift-add (mult) or restoring shift-subtract (div) step each; count decrements.
// - Edge t+WIDTH+1 (FIX): sign correction, hi/lo written, state IDLE; done=1 for that single following cycle.
// - busy=1 from edge t until edge t+WIDTH+1; next start accepted in the done cycle (back-to-back, no bubble).
// - start while busy ignored (stall guarantees pipeline re-presents it).
// - MULT/MULTU: {hi,lo} = full 2*WIDTH product, signed or unsigned.
// - DIV/DIVU: lo=quotient, hi=remainder; signed truncates toward zero, remainder takes dividend sign.
// - Divisor 0: lo = all ones, hi = srca, for signed and unsigned alike; latency unchanged.
// - Signed MIN / -1: lo = MIN, hi = 0 (two's-complement wrap), no trap.
// - hiwe/lowe: write hi/lo at the edge, in any state; if busy, the pending result later overwrites both.
// - hiwe/lowe on the FIX edge: operation result wins.
// - stall is combinational; rd_hilo in IDLE never stalls (hi/lo always readable).
// CONFIGURATION
// - MDU_DIV0_FLAG_EN defined: div0 port present; set at FIX edge of any DIV/DIVU with srcb=0;
//   cleared only by reset or a hiwe/lowe write.
// - MDU_DIV0_FLAG_EN undefined: div0 port absent; divide-by-zero results identical.
// TESTING
// - WIDTH=32, MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, done 1 cycle.
// - MULT -7*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
// - DIVU 100/0 -> lo=0xFFFFFFFF, hi=100; div0=1 with macro; MTLO 5 then clears div0.
// - MULTU launched, rd_hilo=1 at cycle 10 -> stall=1 until done; back-to-back start in done cycle accepted.
// - Reset asserted at iteration 15 -> busy=0, hi=lo=0 immediately; MTHI during RUN then result overwrites.
// - WIDTH=8 regression: DIV 0x80/0xFF -> lo=0x80, hi=0x00 after 9 cycles.

Source files
------------

// File: rtl/mdu_iterative.sv
// mdu_iterative: radix-2 iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Ports: clk; reset (async, active-high); start/op/srca/srcb launch an operation;
// hiwe/lowe/hlwd perform MTHI/MTLO; rd_hilo flags an MFHI/MFLO in EX;
// busy/done/stall report progress; hi/lo are the architectural registers;
// div0 is a sticky divide-by-zero flag, present only when MDU_DIV0_FLAG_EN is defined.
module mdu_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             hiwe,
    input  logic             lowe,
    input  logic [WIDTH-1:0] hlwd,
    input  logic             rd_hilo,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MDU_DIV0_FLAG_EN
    ,
    output logic             div0
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             div_q, div_d;
    logic             neg_q, neg_d;
    logic             nega_q, nega_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
`ifdef MDU_DIV0_FLAG_EN
    logic             div0_q, div0_d;
`endif

    logic               sgn_a, sgn_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shl;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        neg_d   = neg_q;
        nega_d  = nega_q;
        m_d     = m_q;
        acc_d   = acc_q;
        x_d     = x_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
`ifdef MDU_DIV0_FLAG_EN
        div0_d  = div0_q;
`endif

        sgn_a  = srca[WIDTH-1] & ~op[0];
        sgn_b  = srcb[WIDTH-1] & ~op[0];
        abs_a  = sgn_a ? -srca : srca;
        abs_b  = sgn_b ? -srcb : srcb;

        // Multiply: {acc, x} shifts right; x's low bit selects the add.
        addend = x_q[0] ? m_q : '0;
        sum    = {1'b0, acc_q} + {1'b0, addend};

        // Divide: remainder in acc, dividend shifts out of x, quotient in.
        shl    = {acc_q, x_q[WIDTH-1]};
        diff   = shl - {1'b0, m_q};

        prod   = {acc_q, x_q};
        if (neg_q) begin
            prod = -prod;
        end
        quo    = neg_q ? -x_q : x_q;
        rem    = nega_q ? -acc_q : acc_q;

        if (hiwe) begin
            hi_d = hlwd;
        end
        if (lowe) begin
            lo_d = hlwd;
        end
`ifdef MDU_DIV0_FLAG_EN
        if (hiwe | lowe) begin
            div0_d = 1'b0;
        end
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = CW'(WIDTH - 1);
                    div_d   = op[1];
                    neg_d   = sgn_a ^ sgn_b;
                    nega_d  = sgn_a;
                    acc_d   = '0;
                    if (op[1]) begin
                        m_d = abs_b;
                        x_d = abs_a;
                    end else begin
                        m_d = abs_a;
                        x_d = abs_b;
                    end
                end
            end
            S_RUN: begin
                if (div_q) begin
                    if (!diff[WIDTH]) begin
                        acc_d = diff[WIDTH-1:0];
                        x_d   = {x_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = shl[WIDTH-1:0];
                        x_d   = {x_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = sum[WIDTH:1];
                    x_d   = {sum[0], x_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (div_q) begin
                    // Zero divisor: all-ones quotient, remainder restores srca.
                    hi_d = rem;
                    lo_d = (m_q == '0) ? '1 : quo;
`ifdef MDU_DIV0_FLAG_EN
                    if (m_q == '0) begin
                        div0_d = 1'b1;
                    end
`endif
                end else begin
                    {hi_d, lo_d} = prod;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            nega_q  <= 1'b0;
            m_q     <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
            div0_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            nega_q  <= nega_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
`ifdef MDU_DIV0_FLAG_EN
            div0_q  <= div0_d;
`endif
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;
    assign stall = busy & (rd_hilo | start);
    assign hi    = hi_q;
    assign lo    = lo_q;
`ifdef MDU_DIV0_FLAG_EN
    assign div0  = div0_q;
`endif

endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: randomized and directed bench for mdu_iterative at WIDTH=32 and WIDTH=8.
// Expected HI/LO come from a plain-arithmetic reference model of MULT/MULTU/DIV/DIVU.
module tb_mdu_iterative;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, hiwe, lowe, rd_hilo;
    logic [1:0]  op;
    logic [31:0] srca, srcb, hlwd;
    logic        busy, done, stall;
    logic [31:0] hi, lo;
`ifdef MDU_DIV0_FLAG_EN
    logic        div0;
    logic        div0_8;
`endif

    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  srca8, srcb8;
    logic        hiwe8, lowe8, rd8;
    logic [7:0]  hlwd8;
    logic        busy8, done8, stall8;
    logic [7:0]  hi8, lo8;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mdu_iterative #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .srca(srca), .srcb(srcb), .hiwe(hiwe), .lowe(lowe),
        .hlwd(hlwd), .rd_hilo(rd_hilo), .busy(busy), .done(done),
        .stall(stall), .hi(hi), .lo(lo)
`ifdef MDU_DIV0_FLAG_EN
        , .div0(div0)
`endif
    );

    mdu_iterative #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8),
        .srca(srca8), .srcb(srcb8), .hiwe(hiwe8), .lowe(lowe8),
        .hlwd(hlwd8), .rd_hilo(rd8), .busy(busy8), .done(done8),
        .stall(stall8), .hi(hi8), .lo(lo8)
`ifdef MDU_DIV0_FLAG_EN
        , .div0(div0_8)
`endif
    );

    // Reference: n-bit MIPS mult/div semantics from plain 64-bit arithmetic.
    function automatic void model(input int n, input logic [1:0] o,
                                  input logic [63:0] ain, input logic [63:0] bin,
                                  output logic [63:0] eh, output logic [63:0] el);
        logic [63:0] mask, a, b, p;
        longint sa, sb, mn;
        mask = (64'd1 << n) - 64'd1;
        a = ain & mask;
        b = bin & mask;
        sa = longint'(a << (64 - n)) >>> (64 - n);
        sb = longint'(b << (64 - n)) >>> (64 - n);
        mn = -(longint'(1) << (n - 1));
        p = (o == 2'b00) ? 64'(sa * sb) : a * b;
        if (!o[1]) begin
            el = p & mask;
            eh = (p >> n) & mask;
        end else if (b == 0) begin
            el = mask;
            eh = a;
        end else if (o == 2'b11) begin
            el = a / b;
            eh = a % b;
        end else if (sa == mn && sb == -1) begin
            el = a;
            eh = 0;
        end else begin
            el = 64'(sa / sb) & mask;
            eh = 64'(sa % sb) & mask;
        end
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 5))
            0: return 8'h00;
            1: return 8'hFF;
            2: return 8'h80;
            3: return 8'h7F;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o;
        srca = a;
        srcb = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_checked(input string name, input logic [1:0] o,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] eh, input logic [31:0] el);
        int cyc;
        launch(o, a, b);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_after_start: got %b, expected 1", name, busy);
        end
        wait_done(cyc);
        vectors++;
        if (cyc != 33) begin
            miscompares++;
            $display("FAIL %s latency: got %0d, expected 33", name, cyc);
        end
        vectors++;
        if ({hi, lo} !== {eh, el}) begin
            miscompares++;
            $display("FAIL %s result: got hi=%h lo=%h, expected hi=%h lo=%h",
                     name, hi, lo, eh, el);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done_pulse: got done=%b busy=%b, expected 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 0; hiwe = 0; lowe = 0; rd_hilo = 0;
        op = 0; srca = 0; srcb = 0; hlwd = 0;
        start8 = 0; op8 = 0; srca8 = 0; srcb8 = 0;
        hiwe8 = 0; lowe8 = 0; rd8 = 0; hlwd8 = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        rd_hilo = 1'b1;
        #1;
        vectors++;
        if ({busy, done, stall, hi, lo} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%b done=%b stall=%b hi=%h lo=%h, expected all 0",
                     busy, done, stall, hi, lo);
        end
`ifdef MDU_DIV0_FLAG_EN
        vectors++;
        if (div0 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_div0: got %b, expected 0", div0);
        end
`endif
        rd_hilo = 1'b0;
    endtask

    task automatic test_directed();
        logic [1:0]  to [10];
        logic [31:0] ta [10];
        logic [31:0] tb [10];
        logic [31:0] th [10];
        logic [31:0] tl [10];
        to = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b10, 2'b00, 2'b11, 2'b10, 2'b00};
        ta = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'h80000000,
               32'hFFFFFFF9, 32'h80000000, 32'hFFFFFFFF, 32'd7, 32'h7FFFFFFF};
        tb = '{32'hFFFFFFFF, 32'd3, 32'd2, 32'd0, 32'hFFFFFFFF,
               32'd0, 32'h80000000, 32'd16, 32'hFFFFFFFE, 32'hFFFFFFFF};
        th = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'd0,
               32'hFFFFFFF9, 32'h40000000, 32'd15, 32'd1, 32'hFFFFFFFF};
        tl = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000,
               32'hFFFFFFFF, 32'h00000000, 32'h0FFFFFFF, 32'hFFFFFFFD, 32'h80000001};
        for (int i = 0; i < 10; i++) begin
            run_checked($sformatf("directed%0d", i), to[i], ta[i], tb[i], th[i], tl[i]);
        end
    endtask

    task automatic test_random();
        logic [63:0] eh, el;
        logic [1:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom_range(0, 3));
            a = pick32();
            b = pick32();
            model(32, o, {32'd0, a}, {32'd0, b}, eh, el);
            run_checked($sformatf("rand%0d op%0d a=%h b=%h", i, o, a, b),
                        o, a, b, eh[31:0], el[31:0]);
        end
    endtask

    task automatic test_div0();
        run_checked("divu_100_by_0", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF);
`ifdef MDU_DIV0_FLAG_EN
        vectors++;
        if (div0 !== 1'b1) begin
            miscompares++;
            $display("FAIL div0_set: got %b, expected 1", div0);
        end
`endif
        lowe = 1'b1;
        hlwd = 32'd5;
        @(negedge clk);
        lowe = 1'b0;
        vectors++;
        if (lo !== 32'd5 || hi !== 32'd100) begin
            miscompares++;
            $display("FAIL mtlo_idle: got hi=%h lo=%h, expected hi=00000064 lo=00000005", hi, lo);
        end
`ifdef MDU_DIV0_FLAG_EN
        vectors++;
        if (div0 !== 1'b0) begin
            miscompares++;
            $display("FAIL div0_clear: got %b, expected 0", div0);
        end
`endif
    endtask

    task automatic test_stall_back_to_back();
        logic [63:0] eh, el, eh2, el2;
        logic [31:0] a, b;
        int cyc;
        bit bad;
        a = 32'($urandom);
        b = 32'($urandom);
        model(32, 2'b01, {32'd0, a}, {32'd0, b}, eh, el);
        model(32, 2'b10, {32'd0, b}, 64'd7, eh2, el2);
        launch(2'b01, a, b);
        repeat (9) @(negedge clk);
        rd_hilo = 1'b1;
        bad = 0;
        cyc = 9;
        while (done !== 1'b1 && cyc < 200) begin
            #1;
            if (stall !== 1'b1) bad = 1;
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (bad || cyc != 33) begin
            miscompares++;
            $display("FAIL stall_while_busy: got stall_drop=%0d latency=%0d, expected 0 33", bad, cyc);
        end
        // Done cycle: unit idle, a re-presented start must not stall.
        op = 2'b10;
        srca = b;
        srcb = 32'd7;
        start = 1'b1;
        #1;
        vectors++;
        if (stall !== 1'b0 || {hi, lo} !== {eh[31:0], el[31:0]}) begin
            miscompares++;
            $display("FAIL done_cycle: got stall=%b hi=%h lo=%h, expected stall=0 hi=%h lo=%h",
                     stall, hi, lo, eh[31:0], el[31:0]);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b1 || stall !== 1'b1) begin
            miscompares++;
            $display("FAIL back_to_back_accept: got busy=%b stall=%b, expected 1 1", busy, stall);
        end
        rd_hilo = 1'b0;
        wait_done(cyc);
        vectors++;
        if (cyc != 33 || {hi, lo} !== {eh2[31:0], el2[31:0]}) begin
            miscompares++;
            $display("FAIL back_to_back_result: got lat=%0d hi=%h lo=%h, expected 33 hi=%h lo=%h",
                     cyc, hi, lo, eh2[31:0], el2[31:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        logic [63:0] eh, el;
        int cyc;
        bit bad;
        model(32, 2'b00, 64'hFFFFFFF9, 64'd3, eh, el);
        launch(2'b00, 32'hFFFFFFF9, 32'd3);
        repeat (5) @(negedge clk);
        bad = 0;
        op = 2'b11;
        srca = 32'd1000;
        srcb = 32'd3;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (stall !== 1'b1) bad = 1;
            @(negedge clk);
        end
        start = 1'b0;
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL start_busy_stall: got stall low, expected 1");
        end
        wait_done(cyc);
        vectors++;
        if (cyc != 25 || {hi, lo} !== {eh[31:0], el[31:0]}) begin
            miscompares++;
            $display("FAIL start_busy_ignored: got lat=%0d hi=%h lo=%h, expected 25 hi=%h lo=%h",
                     cyc, hi, lo, eh[31:0], el[31:0]);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL start_busy_relaunch: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        run_checked("pre_reset_mult", 2'b00, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFEB);
        launch(2'b01, 32'($urandom), 32'($urandom));
        repeat (15) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({busy, done, hi, lo} !== '0) begin
            miscompares++;
            $display("FAIL async_reset_mid: got busy=%b done=%b hi=%h lo=%h, expected all 0",
                     busy, done, hi, lo);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        vectors++;
        if ({busy, done, hi, lo} !== '0) begin
            miscompares++;
            $display("FAIL reset_abort: got busy=%b done=%b hi=%h lo=%h, expected all 0",
                     busy, done, hi, lo);
        end
    endtask

    task automatic test_hilo_writes();
        logic [63:0] eh, el;
        int cyc;
        hiwe = 1'b1;
        hlwd = 32'hCAFE_0001;
        @(negedge clk);
        hiwe = 1'b0;
        lowe = 1'b1;
        hlwd = 32'hCAFE_0002;
        @(negedge clk);
        lowe = 1'b0;
        vectors++;
        if (hi !== 32'hCAFE_0001 || lo !== 32'hCAFE_0002) begin
            miscompares++;
            $display("FAIL mthi_mtlo_idle: got hi=%h lo=%h, expected cafe0001 cafe0002", hi, lo);
        end
        model(32, 2'b01, 64'd3, 64'd5, eh, el);
        launch(2'b01, 32'd3, 32'd5);
        repeat (4) @(negedge clk);
        hiwe = 1'b1;
        hlwd = 32'h1234_ABCD;
        @(negedge clk);
        hiwe = 1'b0;
        vectors++;
        if (hi !== 32'h1234_ABCD || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mthi_run: got hi=%h busy=%b, expected 1234abcd 1", hi, busy);
        end
        cyc = 5;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (cyc != 33 || {hi, lo} !== {eh[31:0], el[31:0]}) begin
            miscompares++;
            $display("FAIL mthi_run_overwrite: got lat=%0d hi=%h lo=%h, expected 33 hi=%h lo=%h",
                     cyc, hi, lo, eh[31:0], el[31:0]);
        end
        @(negedge clk);
        // MTHI/MTLO coinciding with the result-write edge lose.
        model(32, 2'b11, 64'd1000, 64'd7, eh, el);
        launch(2'b11, 32'd1000, 32'd7);
        repeat (32) @(negedge clk);
        hiwe = 1'b1;
        lowe = 1'b1;
        hlwd = 32'h5A5A_5A5A;
        @(negedge clk);
        hiwe = 1'b0;
        lowe = 1'b0;
        vectors++;
        if (done !== 1'b1 || {hi, lo} !== {eh[31:0], el[31:0]}) begin
            miscompares++;
            $display("FAIL fix_edge_write: got done=%b hi=%h lo=%h, expected 1 hi=%h lo=%h",
                     done, hi, lo, eh[31:0], el[31:0]);
        end
        @(negedge clk);
    endtask

    task automatic run8(input string name, input logic [1:0] o,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eh, input logic [7:0] el);
        int cyc;
        op8 = o;
        srca8 = a;
        srcb8 = b;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        cyc = 0;
        while (done8 !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (cyc != 9 || {hi8, lo8} !== {eh, el}) begin
            miscompares++;
            $display("FAIL %s w8: got lat=%0d hi=%h lo=%h, expected 9 hi=%h lo=%h",
                     name, cyc, hi8, lo8, eh, el);
        end
        @(negedge clk);
    endtask

    task automatic test_width8();
        logic [63:0] eh, el;
        logic [1:0]  o;
        logic [7:0]  a, b;
        run8("div_min_m1", 2'b10, 8'h80, 8'hFF, 8'h00, 8'h80);
        run8("mult_m7x3", 2'b00, 8'hF9, 8'h03, 8'hFF, 8'hEB);
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            a = pick8();
            b = pick8();
            model(8, o, {56'd0, a}, {56'd0, b}, eh, el);
            run8($sformatf("rand8_%0d op%0d a=%h b=%h", i, o, a, b), o, a, b, eh[7:0], el[7:0]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_div0();
        test_random();
        test_stall_back_to_back();
        test_start_while_busy();
        test_hilo_writes();
        test_width8();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
